// File: rtl/mm_req_queue.sv
// Request FIFO between the DMA Wishbone front end and the SDRAM controller.
// Issues one request every third cycle at most and forwards read data in order.
module mm_req_queue #(
    parameter int DEPTH  = 4,
    parameter int RD_MAX = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        up_in_valid,
    input  logic        up_rw,
    input  logic [22:0] up_address,
    input  logic [31:0] up_wdata,
    output logic        up_busy,
    output logic [31:0] up_rdata,
    output logic        up_out_valid,
    output logic        ctrl_in_valid,
    output logic        ctrl_rw,
    output logic [22:0] ctrl_addr,
    output logic [31:0] ctrl_wdata,
    input  logic        ctrl_busy,
    input  logic [31:0] ctrl_rdata,
    input  logic        ctrl_out_valid,
    output logic        rd_underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(RD_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    state;
    logic [55:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [RW-1:0] rd_out;
    logic [RW-1:0] rd_out_nxt;

    logic        head_rw;
    logic [22:0] head_addr;
    logic [31:0] head_wdata;
    logic        push;
    logic        go;
    logic        rd_inc;
    logic        rd_dec;

    assign {head_rw, head_addr, head_wdata} = mem[rd_ptr];

    assign push = up_in_valid && !up_busy;
    // A read head waits while the outstanding-read budget is exhausted; writes never do.
    assign go = (state == S_IDLE) && (count != '0) && !ctrl_busy &&
                (head_rw || (rd_out != RW'(RD_MAX)));
    assign rd_inc = go && !head_rw;
    assign rd_dec = ctrl_out_valid && (rd_out != '0);

    always_comb begin
        count_nxt = count;
        case ({push, go})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        rd_out_nxt = rd_out;
        if (rd_inc && !ctrl_out_valid) begin
            rd_out_nxt = rd_out + 1'b1;
        end else if (!rd_inc && rd_dec) begin
            rd_out_nxt = rd_out - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {up_rw, up_address, up_wdata};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_out        <= '0;
            up_busy       <= 1'b0;
            up_out_valid  <= 1'b0;
            up_rdata      <= '0;
            ctrl_in_valid <= 1'b0;
            ctrl_rw       <= 1'b0;
            ctrl_addr     <= '0;
            ctrl_wdata    <= '0;
            rd_underflow  <= 1'b0;
        end else begin
            count   <= count_nxt;
            rd_out  <= rd_out_nxt;
            up_busy <= (count_nxt == CW'(DEPTH)) || (rd_out_nxt == RW'(RD_MAX));
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            ctrl_in_valid <= go;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state      <= S_ISSUE;
                        rd_ptr     <= rd_ptr + 1'b1;
                        ctrl_rw    <= head_rw;
                        ctrl_addr  <= head_addr;
                        ctrl_wdata <= head_wdata;
                    end
                end
                S_ISSUE: state <= S_GAP;
                default: state <= S_IDLE;
            endcase
            up_out_valid <= ctrl_out_valid;
            if (ctrl_out_valid) begin
                up_rdata <= ctrl_rdata;
                if (rd_out == '0) begin
                    rd_underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_req_queue.sv
// Randomised and directed bench for mm_req_queue, scored against a transaction-level model.
module tb_mm_req_queue;

    localparam int DEPTH  = 4;
    localparam int RD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_in_valid;
    logic        up_rw;
    logic [22:0] up_address;
    logic [31:0] up_wdata;
    logic        up_busy;
    logic [31:0] up_rdata;
    logic        up_out_valid;
    logic        ctrl_in_valid;
    logic        ctrl_rw;
    logic [22:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_busy;
    logic [31:0] ctrl_rdata;
    logic        ctrl_out_valid;
    logic        rd_underflow;

    always #5 clk = ~clk;

    mm_req_queue #(.DEPTH(DEPTH), .RD_MAX(RD_MAX)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .up_in_valid    (up_in_valid),
        .up_rw          (up_rw),
        .up_address     (up_address),
        .up_wdata       (up_wdata),
        .up_busy        (up_busy),
        .up_rdata       (up_rdata),
        .up_out_valid   (up_out_valid),
        .ctrl_in_valid  (ctrl_in_valid),
        .ctrl_rw        (ctrl_rw),
        .ctrl_addr      (ctrl_addr),
        .ctrl_wdata     (ctrl_wdata),
        .ctrl_busy      (ctrl_busy),
        .ctrl_rdata     (ctrl_rdata),
        .ctrl_out_valid (ctrl_out_valid),
        .rd_underflow   (rd_underflow)
    );

    typedef struct {
        logic        rw;
        logic [22:0] addr;
        logic [31:0] data;
    } req_t;

    // Reference model: queue contents, outstanding reads, issue cooldown, expected outputs.
    req_t        q[$];
    req_t        m_last;
    int          m_rd;
    int          m_wait;
    logic        m_busy;
    logic        m_issue;
    logic        m_ovld;
    logic [31:0] m_rdata;
    logic        m_uf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = '{rw: 1'b0, addr: '0, data: '0};
        m_rd    = 0;
        m_wait  = 0;
        m_busy  = 1'b0;
        m_issue = 1'b0;
        m_ovld  = 1'b0;
        m_rdata = '0;
        m_uf    = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic rw, input logic [22:0] a,
                              input logic [31:0] d, input logic cb, input logic cov,
                              input logic [31:0] crd, input logic r);
        logic inc;
        if (r) begin
            model_reset();
            return;
        end
        m_issue = 1'b0;
        if (m_wait > 0) begin
            m_wait--;
        end else if (q.size() > 0 && !cb && (q[0].rw || m_rd != RD_MAX)) begin
            m_issue = 1'b1;
            m_last  = q.pop_front();
            m_wait  = 2;
        end
        inc = m_issue && !m_last.rw;
        if (cov && m_rd == 0) m_uf = 1'b1;
        if (inc && !cov) m_rd++;
        else if (!inc && cov && m_rd > 0) m_rd--;
        if (iv && !m_busy) q.push_back('{rw: rw, addr: a, data: d});
        m_busy = (q.size() == DEPTH) || (m_rd == RD_MAX);
        m_ovld = cov;
        if (cov) m_rdata = crd;
    endtask

    task automatic step(input logic iv, input logic rw, input logic [22:0] a,
                        input logic [31:0] d, input logic cb, input logic cov,
                        input logic [31:0] crd, input logic r);
        up_in_valid    = iv;
        up_rw          = rw;
        up_address     = a;
        up_wdata       = d;
        ctrl_busy      = cb;
        ctrl_out_valid = cov;
        ctrl_rdata     = crd;
        rst            = r;
        @(posedge clk);
        model_edge(iv, rw, a, d, cb, cov, crd, r);
        #1;
        chk("ctrl_in_valid", ctrl_in_valid, m_issue);
        chk("ctrl_rw", ctrl_rw, m_last.rw);
        chk("ctrl_addr", ctrl_addr, m_last.addr);
        chk("ctrl_wdata", ctrl_wdata, m_last.data);
        chk("up_busy", up_busy, m_busy);
        chk("up_out_valid", up_out_valid, m_ovld);
        chk("up_rdata", up_rdata, m_rdata);
        chk("rd_underflow", rd_underflow, m_uf);
    endtask

    task automatic idle(input int n, input logic cb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, cb, 1'b0, '0, 1'b0);
    endtask

    // Hold a request until the queue takes it; bounded so a stuck up_busy cannot hang the run.
    task automatic push_hold(input logic rw, input logic [22:0] a, input logic [31:0] d,
                             input logic cb);
        bit taken = 0;
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = !m_busy;
            step(1'b1, rw, a, d, cb, 1'b0, '0, 1'b0);
        end
        chk("push_accepted", taken, 1'b1);
    endtask

    task automatic ret_read(input logic [31:0] v);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, v, 1'b0);
    endtask

    initial begin
        model_reset();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_busy", up_busy, 1'b0);
        idle(2, 1'b0);

        // Single write: strobe appears in the cycle after the edge following the push.
        step(1'b1, 1'b1, 23'h000010, 32'hDEADBEEF, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("wr_strobe", ctrl_in_valid, 1'b1);
        chk("wr_addr", ctrl_addr, 23'h000010);
        chk("wr_data", ctrl_wdata, 32'hDEADBEEF);
        chk("wr_type", ctrl_rw, 1'b1);
        idle(4, 1'b0);

        // Fill while the controller is busy, then a dropped fifth push, then drain.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 23'(32'h100 + i), 32'hA0000000 + i, 1'b1, 1'b0, '0, 1'b0);
        chk("fill_busy", up_busy, 1'b1);
        step(1'b1, 1'b1, 23'h7FFFFF, 32'hBAD0BAD0, 1'b1, 1'b0, '0, 1'b0);
        chk("fill_busy_held", up_busy, 1'b1);
        idle(15, 1'b0);

        // Read return with one-cycle forwarding latency.
        step(1'b1, 1'b0, 23'h000200, '0, 1'b0, 1'b0, '0, 1'b0);
        idle(4, 1'b0);
        ret_read(32'h12345678);
        chk("rd_ret_vld", up_out_valid, 1'b1);
        chk("rd_ret_data", up_rdata, 32'h12345678);
        idle(2, 1'b0);
        chk("rd_ret_uf", rd_underflow, 1'b0);

        // Throttle: four reads in flight stall a fifth read and the write behind it.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 23'(32'h300 + i), '0, 1'b1, 1'b0, '0, 1'b0);
        push_hold(1'b0, 23'h000304, '0, 1'b0);
        push_hold(1'b1, 23'h000305, 32'h55AA55AA, 1'b0);
        idle(12, 1'b0);
        chk("throttle_busy", up_busy, 1'b1);
        ret_read(32'h00000001);
        idle(10, 1'b0);
        for (int i = 0; i < 5; i++) ret_read(32'h10 + i);
        idle(3, 1'b0);

        // Underflow: data with nothing outstanding is still forwarded and flagged.
        ret_read(32'hCAFEF00D);
        chk("uf_flag", rd_underflow, 1'b1);
        chk("uf_data", up_rdata, 32'hCAFEF00D);
        idle(3, 1'b0);
        chk("uf_sticky", rd_underflow, 1'b1);

        // Reset while a strobe is on the bus discards everything queued.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 23'h000400, 32'h11111111, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 23'h000401, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 23'h000402, 32'h33333333, 1'b0, 1'b0, '0, 1'b0);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                seen = ctrl_in_valid;
                if (!seen) idle(1, 1'b0);
            end
            chk("issue_seen", seen, 1'b1);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_iss_vld", ctrl_in_valid, 1'b0);
        chk("rst_iss_addr", ctrl_addr, 23'h0);
        idle(8, 1'b0);

        // Randomised traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            logic iv, rw, cb, cov, r;
            iv  = ($urandom_range(0, 99) < 60);
            rw  = $urandom_range(0, 1);
            cb  = ($urandom_range(0, 99) < 30);
            cov = (m_rd > 0) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 999) < 3);
            r   = ($urandom_range(0, 999) < 4);
            step(iv, rw, 23'($urandom), $urandom, cb, cov, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
